// File: rtl/core_mem_arbiter.sv
// Purpose: merges NUM_CH core-side memory request channels onto one shared memory port (round-robin or fixed priority).
// Latency: grant registered one cycle after enable, completion visible one cycle after mem_ack_i; 3 cycles minimum per transaction.
// Backpressure: a requesting channel sees ch_blocking_n_o=0 until its completion cycle; WAIT aborts with err_o after TIMEOUT_CYC cycles.
module core_mem_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CH-1:0]              ch_en_i,
  input  logic [NUM_CH*ADDR_W-1:0]       ch_addr_i,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   ch_we_i,
  input  logic [NUM_CH*DATA_W-1:0]       ch_wdata_i,
  output logic [DATA_W-1:0]              ch_rdata_o,
  output logic [NUM_CH-1:0]              ch_blocking_n_o,
  output logic                           mem_req_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  output logic [DATA_W/8-1:0]            mem_we_o,
  output logic [DATA_W-1:0]              mem_wdata_o,
  input  logic                           mem_ack_i,
  input  logic [DATA_W-1:0]              mem_rdata_i,
  output logic                           err_o,
  output logic [$clog2(NUM_CH)-1:0]      err_ch_o
);

  localparam int SW = DATA_W / 8;
  localparam int GW = $clog2(NUM_CH);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [SW-1:0]      mem_we_q, mem_we_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [GW-1:0]      err_ch_q, err_ch_d;

  logic [NUM_CH-1:0]  req;
  logic               arb_vld;
  logic [GW-1:0]      arb_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [SW-1:0]      sel_we;
  logic [DATA_W-1:0]  sel_wdata;

  // Pending requests exclude a channel that is in its completion cycle
  assign req             = ch_en_i & ~done_q;
  assign ch_blocking_n_o = ~req;

  // Pick the winner: search upward from rr_ptr (wrapping) or from index 0, then mux its request fields
  always_comb begin
    int            idx;
    logic [GW-1:0] idx_w;
    arb_vld   = 1'b0;
    arb_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    sel_addr  = '0;
    sel_we    = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (RR_MODE != 0) ? int'(rr_ptr_q) + k : k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_w = GW'(idx);
      if (!arb_vld && req[idx_w]) begin
        arb_vld = 1'b1;
        arb_idx = idx_w;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (arb_idx == GW'(k)) begin
        sel_addr  = ch_addr_i[k*ADDR_W +: ADDR_W];
        sel_we    = ch_we_i[k*SW +: SW];
        sel_wdata = ch_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic for the IDLE -> WAIT -> RESP transaction sequence and all registered outputs
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    done_d      = done_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    err_ch_d    = err_ch_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d     = arb_idx;
          mem_addr_d  = sel_addr;
          mem_we_d    = sel_we;
          mem_wdata_d = sel_wdata;
          mem_req_d   = 1'b1;
          tmo_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (mem_ack_i) begin
          rdata_d         = mem_rdata_i;
          done_d[grant_q] = 1'b1;
          mem_req_d       = 1'b0;
          state_d         = RESP;
        end else if ((TIMEOUT_CYC != 0) && (tmo_q == TW'(TIMEOUT_CYC - 1))) begin
          // Abort: the stalled channel is released with zero data and an error pulse
          rdata_d         = '0;
          err_d           = 1'b1;
          err_ch_d        = grant_q;
          done_d[grant_q] = 1'b1;
          mem_req_d       = 1'b0;
          state_d         = RESP;
        end
      end
      RESP: begin
        done_d   = '0;
        rr_ptr_d = (grant_q == GW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction silently
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_ch_q    <= err_ch_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;
  assign ch_rdata_o  = rdata_q;
  assign err_o       = err_q;
  assign err_ch_o    = err_ch_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: cycle table for read/write/timeout, plus contention, flush and reset sequences.
module tb_core_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  en;
  logic [29:0] a0, a1;
  logic [3:0]  we0, we1;
  logic [31:0] wd0, wd1;
  logic        ack_tb;
  logic [31:0] rin;
  logic        auto_ack;

  logic [59:0] ch_addr;
  logic [7:0]  ch_we;
  logic [63:0] ch_wdata;

  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  bn_a, bn_b;
  logic        req_a, req_b;
  logic [29:0] addr_a, addr_b;
  logic [3:0]  we_a, we_b;
  logic [31:0] wdata_a, wdata_b;
  logic        err_a, err_b;
  logic [0:0]  ech_a, ech_b;
  logic        ack_a, ack_b;

  assign ch_addr  = {a1, a0};
  assign ch_we    = {we1, we0};
  assign ch_wdata = {wd1, wd0};
  assign ack_a    = auto_ack ? req_a : ack_tb;
  assign ack_b    = auto_ack ? req_b : ack_tb;

  core_mem_arbiter #(.NUM_CH(2), .ADDR_W(30), .DATA_W(32), .RR_MODE(1), .TIMEOUT_CYC(4)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .ch_en_i(en), .ch_addr_i(ch_addr), .ch_we_i(ch_we),
    .ch_wdata_i(ch_wdata), .ch_rdata_o(rdata_a), .ch_blocking_n_o(bn_a), .mem_req_o(req_a),
    .mem_addr_o(addr_a), .mem_we_o(we_a), .mem_wdata_o(wdata_a), .mem_ack_i(ack_a),
    .mem_rdata_i(rin), .err_o(err_a), .err_ch_o(ech_a)
  );

  core_mem_arbiter #(.NUM_CH(2), .ADDR_W(30), .DATA_W(32), .RR_MODE(0), .TIMEOUT_CYC(4)) u_fp (
    .clk_i(clk), .rst_ni(rst_n), .ch_en_i(en), .ch_addr_i(ch_addr), .ch_we_i(ch_we),
    .ch_wdata_i(ch_wdata), .ch_rdata_o(rdata_b), .ch_blocking_n_o(bn_b), .mem_req_o(req_b),
    .mem_addr_o(addr_b), .mem_we_o(we_b), .mem_wdata_o(wdata_b), .mem_ack_i(ack_b),
    .mem_rdata_i(rin), .err_o(err_b), .err_ch_o(ech_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic [1:0]  en;
    logic [29:0] a0, a1;
    logic [3:0]  we0;
    logic [31:0] wd0;
    logic        ack;
    logic [31:0] rin;
    logic        e_req;
    logic [29:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wd;
    logic        chk_rd;
    logic [31:0] e_rd;
    logic [1:0]  e_bn;
    logic        e_err;
    logic        e_ech;
  } vec_t;

  function automatic vec_t v(input logic [1:0] en_i, input logic [29:0] a0_i, input logic [29:0] a1_i,
                             input logic [3:0] we0_i, input logic [31:0] wd0_i, input logic ack_i,
                             input logic [31:0] rin_i, input logic e_req_i, input logic [29:0] e_addr_i,
                             input logic [3:0] e_we_i, input logic [31:0] e_wd_i, input logic chk_rd_i,
                             input logic [31:0] e_rd_i, input logic [1:0] e_bn_i, input logic e_err_i,
                             input logic e_ech_i);
    vec_t r;
    r.en = en_i; r.a0 = a0_i; r.a1 = a1_i; r.we0 = we0_i; r.wd0 = wd0_i; r.ack = ack_i; r.rin = rin_i;
    r.e_req = e_req_i; r.e_addr = e_addr_i; r.e_we = e_we_i; r.e_wd = e_wd_i; r.chk_rd = chk_rd_i;
    r.e_rd = e_rd_i; r.e_bn = e_bn_i; r.e_err = e_err_i; r.e_ech = e_ech_i;
    return r;
  endfunction

  localparam int NV = 20;
  vec_t tbl[NV];

  task automatic do_reset();
    rst_n = 1'b0; en = 2'b00; a0 = '0; a1 = '0; we0 = '0; we1 = '0; wd0 = '0; wd1 = '0;
    ack_tb = 1'b0; rin = '0; auto_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [29:0] ga[4], gb[4];
  int na, nb;

  initial begin
    // ch1 read of 0x100, acked on the third WAIT cycle
    tbl[0]  = v(2'b10, 0, 30'h100, 0, 0, 0, 0,            0, 0, 0, 0,                 0, 0, 2'b01, 0, 0);
    tbl[1]  = v(2'b10, 0, 30'h100, 0, 0, 0, 0,            1, 30'h100, 0, 0,           0, 0, 2'b01, 0, 0);
    tbl[2]  = v(2'b10, 0, 30'h100, 0, 0, 0, 0,            1, 30'h100, 0, 0,           0, 0, 2'b01, 0, 0);
    tbl[3]  = v(2'b10, 0, 30'h100, 0, 0, 1, 32'hDEADBEEF, 1, 30'h100, 0, 0,           0, 0, 2'b01, 0, 0);
    tbl[4]  = v(2'b10, 0, 30'h100, 0, 0, 0, 0,            0, 0, 0, 0,                 1, 32'hDEADBEEF, 2'b11, 0, 0);
    tbl[5]  = v(2'b00, 0, 0,       0, 0, 0, 0,            0, 0, 0, 0,                 1, 32'hDEADBEEF, 2'b11, 0, 0);
    // ch0 write of 0x12345678 to 0x40 with strobes 0011
    tbl[6]  = v(2'b01, 30'h40, 0, 4'b0011, 32'h12345678, 0, 0,            0, 0, 0, 0,                            0, 0, 2'b10, 0, 0);
    tbl[7]  = v(2'b01, 30'h40, 0, 4'b0011, 32'h12345678, 0, 0,            1, 30'h40, 4'b0011, 32'h12345678,      0, 0, 2'b10, 0, 0);
    tbl[8]  = v(2'b01, 30'h40, 0, 4'b0011, 32'h12345678, 0, 0,            1, 30'h40, 4'b0011, 32'h12345678,      0, 0, 2'b10, 0, 0);
    tbl[9]  = v(2'b01, 30'h40, 0, 4'b0011, 32'h12345678, 1, 32'hCAFEF00D, 1, 30'h40, 4'b0011, 32'h12345678,      0, 0, 2'b10, 0, 0);
    tbl[10] = v(2'b01, 30'h40, 0, 4'b0011, 32'h12345678, 0, 0,            0, 0, 0, 0,                            1, 32'hCAFEF00D, 2'b11, 0, 0);
    tbl[11] = v(2'b00, 0, 0, 0, 0, 0, 0,                                  0, 0, 0, 0,                            0, 0, 2'b11, 0, 0);
    // ch1 read of 0x55 never acked: four WAIT cycles then abort
    tbl[12] = v(2'b10, 0, 30'h55, 0, 0, 0, 0,            0, 0, 0, 0,           0, 0, 2'b01, 0, 0);
    tbl[13] = v(2'b10, 0, 30'h55, 0, 0, 0, 0,            1, 30'h55, 0, 0,      0, 0, 2'b01, 0, 0);
    tbl[14] = v(2'b10, 0, 30'h55, 0, 0, 0, 0,            1, 30'h55, 0, 0,      0, 0, 2'b01, 0, 0);
    tbl[15] = v(2'b10, 0, 30'h55, 0, 0, 0, 0,            1, 30'h55, 0, 0,      0, 0, 2'b01, 0, 0);
    tbl[16] = v(2'b10, 0, 30'h55, 0, 0, 0, 0,            1, 30'h55, 0, 0,      0, 0, 2'b01, 0, 0);
    tbl[17] = v(2'b10, 0, 30'h55, 0, 0, 0, 0,            0, 0, 0, 0,           1, 0, 2'b11, 1, 1);
    // stray ack in IDLE must not load read data
    tbl[18] = v(2'b00, 0, 0, 0, 0, 1, 32'hBAD0BAD0,      0, 0, 0, 0,           1, 0, 2'b11, 0, 1);
    tbl[19] = v(2'b00, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0,           1, 0, 2'b11, 0, 1);

    do_reset();
    @(negedge clk);
    chk("rst req_a", req_a, 0);     chk("rst addr_a", addr_a, 0);   chk("rst we_a", we_a, 0);
    chk("rst wdata_a", wdata_a, 0); chk("rst rdata_a", rdata_a, 0); chk("rst err_a", err_a, 0);
    chk("rst ech_a", ech_a, 0);     chk("rst bn_a", bn_a, 2'b11);
    chk("rst req_b", req_b, 0);     chk("rst addr_b", addr_b, 0);   chk("rst we_b", we_b, 0);
    chk("rst wdata_b", wdata_b, 0); chk("rst rdata_b", rdata_b, 0); chk("rst err_b", err_b, 0);
    chk("rst ech_b", ech_b, 0);     chk("rst bn_b", bn_b, 2'b11);

    for (int i = 0; i < NV; i++) begin
      step();
      en = tbl[i].en; a0 = tbl[i].a0; a1 = tbl[i].a1; we0 = tbl[i].we0; wd0 = tbl[i].wd0;
      ack_tb = tbl[i].ack; rin = tbl[i].rin;
      @(negedge clk);
      chk($sformatf("v%0d req", i), req_a, tbl[i].e_req);
      chk($sformatf("v%0d bn", i), bn_a, tbl[i].e_bn);
      chk($sformatf("v%0d err", i), err_a, tbl[i].e_err);
      if (tbl[i].e_req) begin
        chk($sformatf("v%0d addr", i), addr_a, tbl[i].e_addr);
        chk($sformatf("v%0d we", i), we_a, tbl[i].e_we);
        chk($sformatf("v%0d wdata", i), wdata_a, tbl[i].e_wd);
      end
      if (tbl[i].chk_rd) begin
        chk($sformatf("v%0d rdata", i), rdata_a, tbl[i].e_rd);
        chk($sformatf("v%0d err_ch", i), ech_a, tbl[i].e_ech);
      end
    end

    // Contention with immediate acks: RR alternates, fixed priority serves only ch0
    do_reset();
    na = 0; nb = 0;
    step();
    en = 2'b11; a0 = 30'h10; a1 = 30'h20; auto_ack = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_a && na < 4) begin ga[na] = addr_a; na++; end
      if (req_b && nb < 4) begin gb[nb] = addr_b; nb++; end
    end
    chk("rr grant count", na, 4);
    chk("fp grant count", nb, 4);
    for (int g = 0; g < 4; g++) begin
      if (g < na) chk($sformatf("rr grant %0d", g), ga[g], (g % 2 == 0) ? 30'h10 : 30'h20);
      if (g < nb) chk($sformatf("fp grant %0d", g), gb[g], 30'h10);
    end

    // Flush: ch1 drops its enable mid-WAIT; transaction still runs to the ack
    do_reset();
    step(); en = 2'b10; a1 = 30'h77;                  // cycle 0
    step();                                           // cycle 1: WAIT
    step(); en = 2'b00;                               // cycle 2: flush
    @(negedge clk); chk("flush req c2", req_a, 1); chk("flush bn c2", bn_a, 2'b11);
    step(); en = 2'b01; a0 = 30'h33;                  // cycle 3
    @(negedge clk); chk("flush req c3", req_a, 1); chk("flush addr c3", addr_a, 30'h77);
    chk("flush bn c3", bn_a, 2'b10);
    step(); ack_tb = 1'b1; rin = 32'h1111;            // cycle 4: ack
    @(negedge clk); chk("flush req c4", req_a, 1);
    step(); ack_tb = 1'b0;                            // cycle 5: RESP
    @(negedge clk); chk("flush req resp", req_a, 0); chk("flush bn resp", bn_a, 2'b10);
    chk("flush rdata", rdata_a, 32'h1111);
    step();                                           // cycle 6: IDLE arbitrates ch0
    @(negedge clk); chk("flush req idle", req_a, 0);
    step();                                           // cycle 7
    @(negedge clk); chk("flush ch0 req", req_a, 1); chk("flush ch0 addr", addr_a, 30'h33);

    // Reset mid-WAIT clears outputs at once and restarts round-robin at ch0
    do_reset();
    step(); en = 2'b01; a0 = 30'h44;
    step(); ack_tb = 1'b1;
    step(); ack_tb = 1'b0;
    step(); en = 2'b00;
    step(); en = 2'b10; a1 = 30'h88;
    step();
    @(negedge clk); chk("rstw req before", req_a, 1); chk("rstw addr before", addr_a, 30'h88);
    #2 rst_n = 1'b0;
    #1 chk("rstw req async", req_a, 0);
    @(posedge clk); #1 rst_n = 1'b1; en = 2'b11;
    @(negedge clk); chk("rstw req idle", req_a, 0);
    step();
    @(negedge clk); chk("rstw req after", req_a, 1); chk("rstw addr after", addr_a, 30'h44);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Parametrised N-channel arbiter. Merges the core's separate instruction-cache and data-cache request ports onto one shared memory port.
- Successor to the fixed two-port core memory interface. Adds channel count, round-robin or fixed-priority mode, and a wait timeout with error reporting.
- Keeps the core-side `blocking_n` stall convention: 0 = busy, core must stall.

Parameters:
- NUM_CH, 2, number of requester channels (>=2). Channel 0 is the data cache and channel 1 the instruction cache in the default integration.
- ADDR_W, 30, word-address width (byte address bits [31:2]).
- DATA_W, 32, data width; byte-strobe width is DATA_W/8.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- TIMEOUT_CYC, 255, maximum cycles spent in WAIT before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- ch_en_i  in  NUM_CH  per-channel request enable, held until that channel's completion cycle.
- ch_addr_i  in  NUM_CH*ADDR_W  flattened word addresses; channel i is at [i*ADDR_W +: ADDR_W].
- ch_we_i  in  NUM_CH*DATA_W/8  flattened byte write strobes; all zero = read.
- ch_wdata_i  in  NUM_CH*DATA_W  flattened write data.
- ch_rdata_o  out  DATA_W  read data, shared by all channels, valid in the completion cycle.
- ch_blocking_n_o  out  NUM_CH  0 = channel stalled, 1 = free or completing.
- mem_req_o  out  1  memory request valid.
- mem_addr_o  out  ADDR_W  memory word address.
- mem_we_o  out  DATA_W/8  memory byte strobes.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_ack_i  in  1  memory completion, single-cycle pulse.
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i.
- err_o  out  1  one-cycle pulse on timeout abort.
- err_ch_o  out  $clog2(NUM_CH)  channel that timed out; holds its value until the next error.

Behaviour:
- Reset values:
  - state = IDLE; rr_ptr = 0; grant = 0; done = 0; timeout counter = 0.
  - mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, ch_rdata_o, err_o, err_ch_o all = 0.
  - Reset aborts any in-flight transaction with no completion pulse.
- ch_blocking_n_o[i] = ~(ch_en_i[i] & ~done[i]), combinational. A channel stalls in the same cycle it raises its enable.
- State IDLE:
  - If any ch_en_i bit is set with its done bit clear, arbitrate:
    - RR_MODE=1: first set bit searching upward from rr_ptr, wrapping at NUM_CH.
    - RR_MODE=0: lowest set index.
  - Register grant, address, strobes and write data; go to WAIT.
- State WAIT:
  - mem_req_o=1; address, strobes and data held stable.
  - On mem_ack_i: register mem_rdata_i into ch_rdata_o; set done[grant] for the next cycle; go to RESP.
  - Timeout counter increments every WAIT cycle. At count == TIMEOUT_CYC-1 with no ack (TIMEOUT_CYC != 0):
    - set ch_rdata_o = 0, err_o = 1, err_ch_o = grant, done[grant] = 1;
    - go to RESP.
- State RESP:
  - mem_req_o=0; done[grant]=1 for exactly this cycle.
  - rr_ptr = (grant+1) mod NUM_CH; go to IDLE.
  - done clears on exit from RESP.
- Latency: enable at cycle 0 -> mem_req_o at cycle 1 -> earliest ack at cycle 1 -> blocking_n=1 at cycle 2. Minimum transaction is 3 cycles.
- Throughput: IDLE does not arbitrate in the cycle after RESP if done is still set. At most one transaction per 3 cycles.
- A channel's enable dropping mid-transaction (flush):
  - The memory transaction still completes; writes commit.
  - The done pulse occurs but is invisible, because blocking_n is already 1.
- mem_ack_i while not in WAIT is ignored.
- Simultaneous requests: losers stay stalled and are served in later rounds.
  - RR_MODE=1 bounds a channel's wait to NUM_CH-1 transactions.
  - RR_MODE=0 permits starvation of higher indices.

Test Plan:
- Single read: ch1 en, addr=0x100 -> mem_req_o at cycle 1 with addr 0x100, we=0. Ack at cycle 3 with rdata 0xDEADBEEF -> ch_rdata_o=0xDEADBEEF and ch_blocking_n_o[1]=1 at cycle 4; blocking_n_o[1]=0 during cycles 0-3.
- Contention with RR_MODE=1: ch0 and ch1 request continuously with immediate acks -> grants alternate 0,1,0,1. With RR_MODE=0 -> only ch0 is ever served.
- Write: ch0 we=4'b0011, wdata=0x12345678, addr=0x40 -> mem_we_o=0011 and mem_wdata_o=0x12345678 held stable until ack; blocking_n_o[0]=1 one cycle after ack.
- Timeout: TIMEOUT_CYC=4, ch1 request, no ack -> mem_req_o high for exactly 4 cycles, then err_o pulse with err_ch_o=1, ch_rdata_o=0, blocking_n_o[1]=1 in that cycle.
- Flush: ch1 en drops at cycle 2 of WAIT -> mem_req_o stays high until ack. Next ch0 request is granted in the cycle after RESP.
- Reset mid-WAIT: drive rst_ni low asynchronously -> mem_req_o=0 immediately; after release, a new request is served from rr_ptr=0.
